// File: rtl/alu_issue.sv
// MIPS ALU issue stage: decodes one instruction into a registered ALU command
// and presents it downstream, delaying MUL/DIV by a fixed latency.
module alu_issue #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] oprd1,
    output logic [31:0] oprd2,
    output logic [3:0]  option,
    output logic        illegal
);

    localparam int unsigned W  = 32;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 4;

    localparam logic [OW-1:0] OP_AND  = 4'b0000;
    localparam logic [OW-1:0] OP_OR   = 4'b0001;
    localparam logic [OW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OW-1:0] OP_XOR  = 4'b0011;
    localparam logic [OW-1:0] OP_SLL  = 4'b0100;
    localparam logic [OW-1:0] OP_SRL  = 4'b0101;
    localparam logic [OW-1:0] OP_SUB  = 4'b0110;
    localparam logic [OW-1:0] OP_SLT  = 4'b0111;
    localparam logic [OW-1:0] OP_MUL  = 4'b1000;
    localparam logic [OW-1:0] OP_DIV  = 4'b1001;
    localparam logic [OW-1:0] OP_SRA  = 4'b1010;
    localparam logic [OW-1:0] OP_NOR  = 4'b1100;
    localparam logic [OW-1:0] OP_MOVE = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [OW-1:0] option;
        logic [W-1:0]  oprd1;
        logic [W-1:0]  oprd2;
        logic          illegal;
    } cmd_t;

    state_t        state;
    logic [CW-1:0] cnt;
    cmd_t          dec;
    logic          accept;
    logic          go_wait;

    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [W-1:0] simm;
    logic [W-1:0] uimm;
    logic [W-1:0] shamt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign simm   = W'($signed(instr[15:0]));
    assign uimm   = W'(instr[15:0]);
    assign shamt  = W'(instr[10:6]);

    // Register specifiers arrive pre-read as rs_val/rt_val.
    logic unused_fields;
    assign unused_fields = ^instr[25:16];

    // Instruction decode; anything unrecognised becomes an illegal MOVE.
    always_comb begin
        dec.option  = OP_MOVE;
        dec.oprd1   = rs_val;
        dec.oprd2   = '0;
        dec.illegal = 1'b1;
        unique case (opcode)
            6'b000000: begin
                dec.illegal = 1'b0;
                dec.oprd2   = rt_val;
                case (funct)
                    6'b100000, 6'b100001: dec.option = OP_ADD;
                    6'b100010, 6'b100011: dec.option = OP_SUB;
                    6'b100100: dec.option = OP_AND;
                    6'b100101: dec.option = OP_OR;
                    6'b100110: dec.option = OP_XOR;
                    6'b100111: dec.option = OP_NOR;
                    6'b101010: dec.option = OP_SLT;
                    6'b011000: dec.option = OP_MUL;
                    6'b011010: dec.option = OP_DIV;
                    6'b000000, 6'b000010, 6'b000011: begin
                        dec.oprd1  = rt_val;
                        dec.oprd2  = shamt;
                        dec.option = (funct == 6'b000000) ? OP_SLL :
                                     (funct == 6'b000010) ? OP_SRL : OP_SRA;
                    end
                    default: begin
                        dec.option  = OP_MOVE;
                        dec.oprd2   = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            6'b001000, 6'b100011, 6'b101011, 6'b001010: begin
                dec.option  = (opcode == 6'b001010) ? OP_SLT : OP_ADD;
                dec.oprd2   = simm;
                dec.illegal = 1'b0;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec.option  = (opcode == 6'b001100) ? OP_AND :
                              (opcode == 6'b001101) ? OP_OR : OP_XOR;
                dec.oprd2   = uimm;
                dec.illegal = 1'b0;
            end
            6'b000100: begin
                dec.option  = OP_SUB;
                dec.oprd2   = rt_val;
                dec.illegal = 1'b0;
            end
            6'b001111: begin
                dec.option  = OP_SLL;
                dec.oprd1   = uimm;
                dec.oprd2   = W'(16);
                dec.illegal = 1'b0;
            end
            default: begin
                dec.option  = OP_MOVE;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Ready depends only on state and downstream ready, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_HOLD:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign go_wait = ((dec.option == OP_MUL) || (dec.option == OP_DIV)) && (MULDIV_LAT > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            oprd1     <= '0;
            oprd2     <= '0;
            option    <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            oprd1   <= dec.oprd1;
            oprd2   <= dec.oprd2;
            option  <= dec.option;
            illegal <= dec.illegal;
            if (go_wait) begin
                state     <= S_WAIT;
                cnt       <= CW'(MULDIV_LAT - 1);
                out_valid <= 1'b0;
            end else begin
                state     <= S_HOLD;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    // Countdown reaches zero on the edge that presents the command.
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: timestamp-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_issue;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] oprd1;
    logic [31:0] oprd2;
    logic [3:0]  option;
    logic        illegal;

    alu_issue #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .oprd1(oprd1), .oprd2(oprd2), .option(option), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  opt;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    int vectors = 0;
    int errors  = 0;
    int n_xfer  = 0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        exp_t r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] simm;
        logic [31:0] uimm;
        logic [31:0] sh;
        op   = i[31:26];
        fn   = i[5:0];
        simm = {{16{i[15]}}, i[15:0]};
        uimm = {16'h0, i[15:0]};
        sh   = {27'h0, i[10:6]};
        r    = '{4'hF, rs, 32'h0, 1'b1};
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: r = '{4'h2, rs, rt, 1'b0};
                6'h22, 6'h23: r = '{4'h6, rs, rt, 1'b0};
                6'h24: r = '{4'h0, rs, rt, 1'b0};
                6'h25: r = '{4'h1, rs, rt, 1'b0};
                6'h26: r = '{4'h3, rs, rt, 1'b0};
                6'h27: r = '{4'hC, rs, rt, 1'b0};
                6'h2A: r = '{4'h7, rs, rt, 1'b0};
                6'h18: r = '{4'h8, rs, rt, 1'b0};
                6'h1A: r = '{4'h9, rs, rt, 1'b0};
                6'h00: r = '{4'h4, rt, sh, 1'b0};
                6'h02: r = '{4'h5, rt, sh, 1'b0};
                6'h03: r = '{4'hA, rt, sh, 1'b0};
                default: ;
            endcase
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) r = '{4'h2, rs, simm, 1'b0};
        else if (op == 6'h0A) r = '{4'h7, rs, simm, 1'b0};
        else if (op == 6'h0C) r = '{4'h0, rs, uimm, 1'b0};
        else if (op == 6'h0D) r = '{4'h1, rs, uimm, 1'b0};
        else if (op == 6'h0E) r = '{4'h3, rs, uimm, 1'b0};
        else if (op == 6'h04) r = '{4'h6, rs, rt, 1'b0};
        else if (op == 6'h0F) r = '{4'h4, uimm, 32'd16, 1'b0};
        return r;
    endfunction

    // Model: one held command, visible from a computed cycle stamp onward.
    logic        m_has;
    int          m_ready;
    int          cyc;
    exp_t        m_out;
    logic        m_valid;
    logic        m_inrdy;
    exp_t        cur_dec;
    logic        cur_md;

    always_comb begin
        m_valid = m_has && (cyc >= m_ready);
        m_inrdy = !m_has || (m_valid && out_ready);
        cur_dec = ref_dec(instr, rs_val, rt_val);
        cur_md  = (cur_dec.opt == 4'h8) || (cur_dec.opt == 4'h9);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has   <= 1'b0;
            m_ready <= 0;
            cyc     <= 0;
            m_out   <= '0;
        end else begin
            cyc <= cyc + 1;
            if (m_valid && out_ready) m_has <= 1'b0;
            if (in_valid && m_inrdy) begin
                m_has   <= 1'b1;
                m_out   <= cur_dec;
                m_ready <= cyc + 1 + (cur_md ? int'(LAT) - 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", 69'(out_valid), 69'(m_valid));
            chk("in_ready", 69'(in_ready), 69'(m_inrdy));
            chk("command", {option, oprd1, oprd2, illegal}, m_out);
            if (out_valid && out_ready) n_xfer++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = v;
        instr    = i;
        rs_val   = rs;
        rt_val   = rt;
    endtask

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_ADDI = 32'h2022FFFC;
    localparam logic [31:0] I_ORI  = 32'h3422FFFC;
    localparam logic [31:0] I_LUI  = 32'h3C021234;
    localparam logic [31:0] I_MULT = 32'h00220018;
    localparam logic [31:0] I_DIV  = 32'h0022001A;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_SRA  = 32'h00021903;

    initial begin
        int n0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        put(1'b0, 32'h0, 32'h0, 32'h0);

        // Pin the model against hand-decoded literals.
        chk("model_add",  ref_dec(I_ADD, 32'd5, 32'd7), {4'h2, 32'd5, 32'd7, 1'b0});
        chk("model_addi", ref_dec(I_ADDI, 32'd10, 32'd0), {4'h2, 32'd10, 32'hFFFFFFFC, 1'b0});
        chk("model_lui",  ref_dec(I_LUI, 32'd9, 32'd0), {4'h4, 32'h1234, 32'd16, 1'b0});
        chk("model_sra",  ref_dec(I_SRA, 32'd1, 32'h80000000), {4'hA, 32'h80000000, 32'd4, 1'b0});
        chk("model_bad",  ref_dec(I_BAD, 32'h55, 32'h66), {4'hF, 32'h55, 32'h0, 1'b1});

        #3;
        chk("rst_out_valid", 69'(out_valid), 69'(0));
        chk("rst_in_ready", 69'(in_ready), 69'(1));
        chk("rst_cmd", {option, oprd1, oprd2, illegal}, 69'(0));
        step();
        step();
        rst_n = 1'b1;

        put(1'b1, I_ADD, 32'd5, 32'd7);
        step();
        chk("add_cmd", {out_valid, option, oprd1, oprd2, illegal}, {1'b1, 4'h2, 32'd5, 32'd7, 1'b0});
        put(1'b0, I_ADD, 32'd5, 32'd7);
        step();

        put(1'b1, I_ADDI, 32'd10, 32'd3);
        step();
        chk("addi_cmd", {option, oprd1, oprd2}, {4'h2, 32'd10, 32'hFFFFFFFC});
        put(1'b1, I_ORI, 32'd10, 32'd3);
        step();
        chk("ori_cmd", {option, oprd2}, {4'h1, 32'h0000FFFC});
        put(1'b1, I_LUI, 32'd9, 32'd3);
        step();
        chk("lui_cmd", {option, oprd1, oprd2}, {4'h4, 32'h1234, 32'd16});
        put(1'b0, I_LUI, 32'd9, 32'd3);
        step();

        // MUL latency with a follow-on ADD waiting upstream.
        put(1'b1, I_MULT, 32'd6, 32'd7);
        step();
        put(1'b1, I_ADD, 32'd1, 32'd2);
        for (int k = 0; k < 3; k++) begin
            chk("mul_wait_valid", 69'(out_valid), 69'(0));
            chk("mul_wait_ready", 69'(in_ready), 69'(0));
            step();
        end
        chk("mul_present", {out_valid, option, oprd1}, {1'b1, 4'h8, 32'd6});
        step();
        put(1'b0, I_ADD, 32'd1, 32'd2);
        step();

        // Back-to-back stream of four ADDs.
        n0 = n_xfer;
        for (int k = 0; k < 4; k++) begin
            put(1'b1, I_ADD, 32'(100 + k), 32'(k));
            chk("stream_ready", 69'(in_ready), 69'(1));
            step();
        end
        put(1'b0, I_ADD, 32'd0, 32'd0);
        step();
        chk("stream_xfers", 69'(n_xfer - n0), 69'(4));

        // Downstream stall holds the command and blocks upstream.
        put(1'b1, I_ADD, 32'd77, 32'd1);
        step();
        out_ready = 1'b0;
        put(1'b1, I_ADD, 32'd88, 32'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold", {in_ready, out_valid, oprd1}, {1'b0, 1'b1, 32'd77});
        end
        out_ready = 1'b1;
        step();
        chk("stall_release", 69'(oprd1), 69'(88));
        put(1'b0, I_ADD, 32'd0, 32'd0);
        step();

        put(1'b1, I_BAD, 32'h55, 32'h66);
        step();
        chk("illegal_cmd", {option, oprd1, oprd2, illegal}, {4'hF, 32'h55, 32'h0, 1'b1});
        put(1'b1, I_SRA, 32'd1, 32'h80000000);
        step();
        chk("sra_cmd", {option, oprd1, oprd2, illegal}, {4'hA, 32'h80000000, 32'd4, 1'b0});
        put(1'b0, I_SRA, 32'd0, 32'd0);
        step();

        // Reset in the middle of a DIV countdown.
        put(1'b1, I_DIV, 32'd9, 32'd3);
        step();
        put(1'b0, I_DIV, 32'd9, 32'd3);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cmd", {out_valid, option, oprd1}, {1'b0, 4'h0, 32'd0});
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", {in_ready, out_valid}, {1'b1, 1'b0});
        n0 = n_xfer;
        repeat (6) step();
        chk("midrst_no_stale", 69'(n_xfer - n0), 69'(0));

        put(1'b1, I_ADD, 32'd3, 32'd4);
        step();
        chk("post_rst_add", {out_valid, oprd1, oprd2}, {1'b1, 32'd3, 32'd4});
        put(1'b0, I_ADD, 32'd0, 32'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
